pipe_tag_tracker: RTL
=====================

// Module: pipe_tag_tracker
// PURPOSE
//  Tracks per-instruction register tags and control bits through the ID/EX/MEM/WB pipeline registers.
//  Produces the stage-tagged sources, destinations and enables that the hazard/forwarding controller consumes.
//  Applies that controller's pc_en/IF_en/ID_stall/br_clr commands.
//  Also keeps a per-register write-pending scoreboard.
//  Sits between the instruction decoder and the hazard controller, next to the datapath pipeline registers.
// PARAMETERS
//  REG_AW    2   register-address width (NUM_REGS = 2**REG_AW)
//  CNT_W     16  width of the performance counters (used only when PIPE_PERF_CNT_EN is defined)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       reset, synchronous, active-low
//  if_valid       in   1       decoder holds a valid instruction
//  ra             in   REG_AW  decoder field A (destination/source A)
//  rb             in   REG_AW  decoder field B (source B)
//  dec_wb_en      in   1       instruction writes register ra
//  dec_mem_read   in   1       instruction is a load
//  dec_store      in   1       instruction is a store
//  dec_out        in   1       instruction is an output op
//  pc_en          in   1       from hazard ctrl; informational only, no effect on state
//  IF_en          in   1       from hazard ctrl; load IF->ID register
//  ID_stall       in   1       from hazard ctrl; hold ID, bubble into EX
//  br_clr         in   1       from hazard ctrl; flush ID and EX
//  ra_ID, rb_ID   out  REG_AW  ID-stage tags
//  ra_EX, ra_MEM  out  REG_AW  EX/MEM destination tags
//  wb_reg_en_EX   out  1       valid & wb_en in EX
//  wb_reg_en_MEM  out  1       valid & wb_en in MEM
//  mem_read       out  1       valid & load in EX
//  id_store_stall out  1       valid & store in ID
//  id_out_en      out  1       valid & out in ID
//  stage_valid    out  4       {WB,MEM,EX,ID} valid bits
//  pending        out  2**REG_AW  bit r set when any in-flight write to r exists
//  stall_cnt      out  CNT_W   cycles with ID_stall=1 (perf)
//  flush_cnt      out  CNT_W   cycles with br_clr=1 (perf)
// BEHAVIOUR
//  Reset (rst=0 at posedge): all valids=0, all tags=0, all scoreboard counts=0, perf counters=0.
//    Every output reads 0 the cycle after reset. Reset overrides every other input on the same edge.
//  ID load: if IF_en & !ID_stall then ID <= {if_valid, ra, rb, ctrl bits}; else ID holds. Latency 1 cycle.
//  EX load: if ID_stall then EX <= bubble (valid=0, enables=0, tags held); else EX <= ID.
//  MEM <= EX, WB <= MEM unconditionally every cycle.
//  br_clr=1: ID.valid<=0 and EX.valid<=0 on that edge. Beats IF_en and ID_stall. MEM/WB unaffected.
//  All control outputs are ANDed with their stage valid. Tags are raw register contents.
//  Scoreboard: one 2-bit count per register.
//    +1 when a valid wb_en instruction enters EX; -1 when a valid wb_en instruction leaves WB.
//    Inc and dec on the same register in the same cycle: count unchanged.
//    Count never exceeds 3 (EX/MEM/WB); a simulation assertion flags overflow or underflow.
//    pending[r] = (count[r] != 0).
//  A flushed EX instruction never reaches WB, so its increment is reversed on the flush edge.
//    Net count change on that edge = (flushed EX dest ? -1 : 0) + WB retire.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: stall_cnt/flush_cnt count cycles with ID_stall=1 / br_clr=1.
//    Both saturate at all-ones and clear on reset.
//  PIPE_PERF_CNT_EN undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.
// STRUCTURE
//  Package pipe_pkg: REG_AW, NUM_REGS, stage_t typedef {valid, ra, rb, wb_en, mem_rd, store, out},
//    and STAGE_BUBBLE constant.
//  Sub-module pipe_stage_reg: one stage_t register with load/clear/hold.
//    Instantiated for ID, EX, MEM and WB; scoreboard and perf counters live in the top.
// TESTING
//  Reset mid-stream: 3 valid wb instrs in flight, rst=0 one cycle -> stage_valid=0, pending=0.
//  Straight-line flow: issue ra=1,2,3 with wb_en, IF_en=1 -> ra_EX=1 at cycle 2, ra_MEM=1 at cycle 3.
//    pending=4'b1110 while in flight; pending=0 after WB drains.
//  Load-use stall: ID_stall=1 for 1 cycle -> ID holds, EX valid=0, wb_reg_en_EX=0.
//    ID advances on the next cycle; stall_cnt=1 (perf on).
//  Flush: br_clr=1 with wb instr ra=2 in EX -> ID/EX valid=0.
//    count[2] back to 0 next cycle; MEM instr still retires; flush_cnt=1.
//  Simultaneous issue/retire on r=3: count[3] unchanged.
//    br_clr together with ID_stall -> flush wins, ID invalid.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - stage record type and helpers shared by the pipeline tag tracker
package pipe_pkg;

  localparam int REG_AW   = 2;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              wb_en;
    logic              mem_rd;
    logic              store;
    logic              out;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Kill an instruction but keep its tags, so tag outputs do not glitch on bubbles.
  function automatic stage_t squash(input stage_t s);
    stage_t r;
    r        = s;
    r.valid  = 1'b0;
    r.wb_en  = 1'b0;
    r.mem_rd = 1'b0;
    r.store  = 1'b0;
    r.out    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline stage register with clear-over-load priority
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clr,
  input  stage_t din,
  output stage_t dout
);

  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_d = stage_q;
    if (clr) begin
      stage_d = squash(stage_q);
    end else if (load) begin
      stage_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q;

endmodule

// File: rtl/pipe_tag_tracker.sv
// rtl/pipe_tag_tracker.sv - ID/EX/MEM/WB tag and control tracking with write-pending scoreboard
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_tag_tracker
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [REG_AW-1:0]   ra,
  input  logic [REG_AW-1:0]   rb,
  input  logic                dec_wb_en,
  input  logic                dec_mem_read,
  input  logic                dec_store,
  input  logic                dec_out,
  input  logic                pc_en,
  input  logic                IF_en,
  input  logic                ID_stall,
  input  logic                br_clr,
  output logic [REG_AW-1:0]   ra_ID,
  output logic [REG_AW-1:0]   rb_ID,
  output logic [REG_AW-1:0]   ra_EX,
  output logic [REG_AW-1:0]   ra_MEM,
  output logic                wb_reg_en_EX,
  output logic                wb_reg_en_MEM,
  output logic                mem_read,
  output logic                id_store_stall,
  output logic                id_out_en,
  output logic [3:0]          stage_valid,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  stage_t id_din, mem_din;
  stage_t id_s, ex_s, mem_s, wb_s;

  always_comb begin
    id_din        = STAGE_BUBBLE;
    id_din.valid  = if_valid;
    id_din.ra     = ra;
    id_din.rb     = rb;
    id_din.wb_en  = dec_wb_en;
    id_din.mem_rd = dec_mem_read;
    id_din.store  = dec_store;
    id_din.out    = dec_out;
  end

  // A flush kills the EX occupant, so it must not travel on into MEM.
  assign mem_din = br_clr ? squash(ex_s) : ex_s;

  pipe_stage_reg u_id  (.clk(clk), .rst(rst), .load(IF_en & ~ID_stall), .clr(br_clr),
                        .din(id_din), .dout(id_s));
  pipe_stage_reg u_ex  (.clk(clk), .rst(rst), .load(1'b1), .clr(br_clr | ID_stall),
                        .din(id_s), .dout(ex_s));
  pipe_stage_reg u_mem (.clk(clk), .rst(rst), .load(1'b1), .clr(1'b0),
                        .din(mem_din), .dout(mem_s));
  pipe_stage_reg u_wb  (.clk(clk), .rst(rst), .load(1'b1), .clr(1'b0),
                        .din(mem_s), .dout(wb_s));

  logic [NUM_REGS-1:0][1:0] cnt_d;
  logic [NUM_REGS-1:0][1:0] cnt_q;
  logic                     sb_err;

  // Biased by 4 so a transient negative result stays representable for the range check.
  always_comb begin
    logic       up, sq, rt;
    logic [3:0] sum_v;
    cnt_d  = cnt_q;
    sb_err = 1'b0;
    up     = 1'b0;
    sq     = 1'b0;
    rt     = 1'b0;
    sum_v  = 4'd0;
    for (int r = 0; r < NUM_REGS; r++) begin
      up    = id_s.valid & id_s.wb_en & ~ID_stall & ~br_clr & (id_s.ra == REG_AW'(r));
      sq    = ex_s.valid & ex_s.wb_en & br_clr & (ex_s.ra == REG_AW'(r));
      rt    = wb_s.valid & wb_s.wb_en & (wb_s.ra == REG_AW'(r));
      sum_v = 4'd4 + {2'b00, cnt_q[r]} + {3'b000, up} - {3'b000, sq} - {3'b000, rt};
      if (sum_v < 4'd4 || sum_v > 4'd7) begin
        sb_err = 1'b1;
      end
      cnt_d[r] = sum_v[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_sb_range : assert property (@(posedge clk) disable iff (!rst) !sb_err);

  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = (cnt_q[r] != 2'd0);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ID_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br_clr && !(&flush_cnt_q))   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign ra_ID          = id_s.ra;
  assign rb_ID          = id_s.rb;
  assign ra_EX          = ex_s.ra;
  assign ra_MEM         = mem_s.ra;
  assign wb_reg_en_EX   = ex_s.valid & ex_s.wb_en;
  assign wb_reg_en_MEM  = mem_s.valid & mem_s.wb_en;
  assign mem_read       = ex_s.valid & ex_s.mem_rd;
  assign id_store_stall = id_s.valid & id_s.store;
  assign id_out_en      = id_s.valid & id_s.out;
  assign stage_valid    = {wb_s.valid, mem_s.valid, ex_s.valid, id_s.valid};

  // pc_en is advisory and WB only needs its dest/enable fields.
  logic unused_inputs;
  assign unused_inputs = ^{pc_en, wb_s.rb, wb_s.mem_rd, wb_s.store, wb_s.out};

endmodule
